// File: rtl/lc3_branch_unit.sv
// -----------------------------------------------------------------------------
// lc3_branch_unit
//
// Resolves one LC-3 control-flow instruction at a time (BR, JMP/RET, JSR/JSRR).
// It snapshots the instruction, the incremented PC, the BaseR value and the
// n/z/p flags, evaluates the branch condition and target, and then issues a
// one-cycle PC redirect (plus an R7 link write for JSR/JSRR) followed by a
// one-cycle completion strobe. All outputs are registered.
//
// Optional feature: define LC3_BRANCH_STATS_EN to build the saturating
// taken / not-taken statistics counters. Without it both count ports are 0.
//
// Ports:
//   clk              clock, rising edge
//   reset            synchronous, active-low reset
//   req_valid        instruction request valid
//   req_ready        unit idle and able to accept
//   ir               instruction word
//   pc               incremented PC (PC+1) of the instruction
//   base_data        BaseR contents for JMP/JSRR
//   n_flag/z_flag/p_flag  current condition codes
//   pc_load          one-cycle strobe: load pc_next into PC
//   pc_next          redirect target (holds between strobes)
//   link_we          one-cycle R7 write strobe
//   link_data        value written to R7 (holds between strobes)
//   done             one-cycle completion strobe
//   bad_op           asserted with done for an unsupported opcode
//   taken_count      taken-redirect counter
//   not_taken_count  not-taken counter (includes bad_op)
// -----------------------------------------------------------------------------
module lc3_branch_unit #(
  parameter int WIDTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       ir,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  base_data,
  input  logic              n_flag,
  input  logic              z_flag,
  input  logic              p_flag,
  output logic              pc_load,
  output logic [WIDTH-1:0]  pc_next,
  output logic              link_we,
  output logic [WIDTH-1:0]  link_data,
  output logic              done,
  output logic              bad_op,
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] not_taken_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  state_t state, next_state;

  // Snapshot taken at acceptance; later input changes never affect the result.
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] base_q;
  logic [2:0]       nzp_q;

  // Decision registered when leaving EVAL.
  logic             link_q;
  logic             bad_q;
  logic [WIDTH-1:0] target_q;

  // Decode results, valid while in EVAL.
  logic             taken_d;
  logic             link_d;
  logic             bad_d;
  logic [WIDTH-1:0] target_d;

  logic accept;

  // req_ready is itself the registered IDLE indication, so it also gates
  // acceptance in the first IDLE cycle after DONE or after reset release.
  assign accept = (state == IDLE) && req_valid && req_ready;

  // Instruction decode and target computation. Arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    taken_d  = 1'b0;
    link_d   = 1'b0;
    bad_d    = 1'b0;
    target_d = base_q;
    unique case (ir_q[15:12])
      OP_BR: begin
        taken_d  = |(ir_q[11:9] & nzp_q);
        target_d = pc_q + {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
      end
      OP_JMP: begin
        taken_d  = 1'b1;
        target_d = base_q;
      end
      OP_JSR: begin
        taken_d  = 1'b1;
        link_d   = 1'b1;
        // ir[11] selects JSR (PC-relative) versus JSRR (BaseR). JSRR uses the
        // base value captured before the link write, so BaseR=R7 is safe.
        target_d = ir_q[11] ? pc_q + {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]}
                            : base_q;
      end
      default: begin
        bad_d = 1'b1;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (accept) next_state = EVAL;
      EVAL:     next_state = taken_d ? REDIRECT : DONE;
      REDIRECT: next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State, snapshot and registered outputs. Outputs are derived from the
  // current state, so each strobe appears one cycle after its state is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees pre-edge values regardless of statement order.
      state     <= IDLE;
      req_ready <= 1'b0;
      pc_load   <= 1'b0;
      link_we   <= 1'b0;
      done      <= 1'b0;
      bad_op    <= 1'b0;
      pc_next   <= '0;
      link_data <= '0;
      ir_q      <= '0;
      pc_q      <= '0;
      base_q    <= '0;
      nzp_q     <= '0;
      link_q    <= 1'b0;
      bad_q     <= 1'b0;
      target_q  <= '0;
    end else begin
      state     <= next_state;
      req_ready <= (state == IDLE) && !accept;
      pc_load   <= (state == REDIRECT);
      link_we   <= (state == REDIRECT) && link_q;
      done      <= (state == DONE);
      bad_op    <= (state == DONE) && bad_q;

      if (state == REDIRECT) begin
        pc_next <= target_q;
        if (link_q) link_data <= pc_q;
      end

      if (accept) begin
        ir_q   <= ir;
        pc_q   <= pc;
        base_q <= base_data;
        nzp_q  <= {n_flag, z_flag, p_flag};
      end

      if (state == EVAL) begin
        link_q   <= link_d;
        bad_q    <= bad_d;
        target_q <= target_d;
      end
    end
  end

`ifdef LC3_BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q;
  logic [STAT_W-1:0] not_taken_cnt_q;

  // Both counters count the EVAL exit: into REDIRECT or straight to DONE.
  // They stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (state == EVAL) begin
      if (taken_d) begin
        if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
      end else begin
        if (not_taken_cnt_q != '1) not_taken_cnt_q <= not_taken_cnt_q + 1'b1;
      end
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = not_taken_cnt_q;
`else
  assign taken_count     = '0;
  assign not_taken_count = '0;
`endif

endmodule

// File: tb/tb_lc3_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_lc3_branch_unit
//
// Drives directed and randomized control-flow instructions into
// lc3_branch_unit and compares every cycle of each transaction against a
// behavioural model of the LC-3 branch rules. Cycle k is sampled 1 time unit
// after the k-th rising edge following the acceptance edge.
// -----------------------------------------------------------------------------
module tb_lc3_branch_unit;

  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [15:0]       ir = '0;
  logic [15:0]       pc = '0;
  logic [15:0]       base_data = '0;
  logic              n_flag = 1'b0;
  logic              z_flag = 1'b0;
  logic              p_flag = 1'b0;
  logic              pc_load;
  logic [15:0]       pc_next;
  logic              link_we;
  logic [15:0]       link_data;
  logic              done;
  logic              bad_op;
  logic [STAT_W-1:0] taken_count;
  logic [STAT_W-1:0] not_taken_count;

  lc3_branch_unit #(.WIDTH(16), .STAT_W(STAT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .ir              (ir),
    .pc              (pc),
    .base_data       (base_data),
    .n_flag          (n_flag),
    .z_flag          (z_flag),
    .p_flag          (p_flag),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .link_we         (link_we),
    .link_data       (link_data),
    .done            (done),
    .bad_op          (bad_op),
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int n_bad = 0;

  // Reference state the model carries between transactions.
  logic [15:0] exp_pc_next = '0;
  logic [15:0] exp_link    = '0;
  int          exp_taken   = 0;
  int          exp_ntaken  = 0;

  typedef struct {
    bit          taken;
    bit          link;
    bit          bad;
    logic [15:0] target;
  } result_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // LC-3 control-flow semantics computed with plain integer arithmetic.
  function automatic result_t model(input logic [15:0] i_ir, input logic [15:0] i_pc,
                                    input logic [15:0] i_base, input bit n, input bit z,
                                    input bit p);
    result_t r;
    int off;
    r.taken  = 0;
    r.link   = 0;
    r.bad    = 0;
    r.target = '0;
    case (i_ir[15:12])
      4'd0: begin
        r.taken = (i_ir[11] && n) || (i_ir[10] && z) || (i_ir[9] && p);
        off = int'(i_ir[8:0]);
        if (i_ir[8]) off -= 512;
        r.target = 16'((int'(i_pc) + off) % 65536);
      end
      4'd12: begin
        r.taken  = 1;
        r.target = i_base;
      end
      4'd4: begin
        r.taken = 1;
        r.link  = 1;
        if (i_ir[11]) begin
          off = int'(i_ir[10:0]);
          if (i_ir[10]) off -= 2048;
          r.target = 16'((int'(i_pc) + off) % 65536);
        end else begin
          r.target = i_base;
        end
      end
      default: r.bad = 1;
    endcase
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << STAT_W) - 1) ? v : v + 1;
  endfunction

  task automatic check_counters(input string tag);
`ifdef LC3_BRANCH_STATS_EN
    check({tag, ".taken_count"}, 32'(taken_count), 32'(exp_taken));
    check({tag, ".not_taken_count"}, 32'(not_taken_count), 32'(exp_ntaken));
`else
    check({tag, ".taken_count"}, 32'(taken_count), 32'd0);
    check({tag, ".not_taken_count"}, 32'(not_taken_count), 32'd0);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  // One full transaction. Flags n2/z2/p2 are applied right after capture and
  // must not influence the outcome. The request inputs are scrambled while
  // the unit is busy; those requests must be ignored.
  task automatic run(input string tag, input logic [15:0] i_ir, input logic [15:0] i_pc,
                     input logic [15:0] i_base, input bit n, input bit z, input bit p,
                     input bit n2, input bit z2, input bit p2);
    result_t r;
    r = model(i_ir, i_pc, i_base, n, z, p);
    wait_ready(tag);
    ir = i_ir; pc = i_pc; base_data = i_base;
    n_flag = n; z_flag = z; p_flag = p;
    req_valid = 1'b1;
    @(posedge clk); #1;                       // acceptance edge = cycle 0
    req_valid = 1'($urandom % 2);
    ir = 16'($urandom); pc = 16'($urandom); base_data = 16'($urandom);
    n_flag = n2; z_flag = z2; p_flag = p2;

    if (r.taken) exp_taken = sat_inc(exp_taken);
    else         exp_ntaken = sat_inc(exp_ntaken);

    @(posedge clk); #1;                       // cycle 1
    check({tag, ".c1.req_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".c1.pc_load"}, 32'(pc_load), 32'd0);
    check({tag, ".c1.done"}, 32'(done), 32'd0);

    @(posedge clk); #1;                       // cycle 2
    req_valid = 1'b0;
    if (r.taken) begin
      exp_pc_next = r.target;
      if (r.link) exp_link = i_pc;
      check({tag, ".c2.pc_load"}, 32'(pc_load), 32'd1);
      check({tag, ".c2.pc_next"}, 32'(pc_next), 32'(exp_pc_next));
      check({tag, ".c2.link_we"}, 32'(link_we), 32'(r.link));
      check({tag, ".c2.link_data"}, 32'(link_data), 32'(exp_link));
      check({tag, ".c2.done"}, 32'(done), 32'd0);

      @(posedge clk); #1;                     // cycle 3
      check({tag, ".c3.done"}, 32'(done), 32'd1);
      check({tag, ".c3.bad_op"}, 32'(bad_op), 32'd0);
      check({tag, ".c3.pc_load"}, 32'(pc_load), 32'd0);
      check({tag, ".c3.link_we"}, 32'(link_we), 32'd0);
      check({tag, ".c3.pc_next_hold"}, 32'(pc_next), 32'(exp_pc_next));
      check_counters({tag, ".c3"});
      check({tag, ".c3.req_ready"}, 32'(req_ready), 32'd0);

      @(posedge clk); #1;                     // cycle 4
      check({tag, ".c4.req_ready"}, 32'(req_ready), 32'd1);
      check({tag, ".c4.done"}, 32'(done), 32'd0);
    end else begin
      check({tag, ".c2.done"}, 32'(done), 32'd1);
      check({tag, ".c2.bad_op"}, 32'(bad_op), 32'(r.bad));
      check({tag, ".c2.pc_load"}, 32'(pc_load), 32'd0);
      check({tag, ".c2.link_we"}, 32'(link_we), 32'd0);
      check({tag, ".c2.pc_next_hold"}, 32'(pc_next), 32'(exp_pc_next));
      check({tag, ".c2.link_hold"}, 32'(link_data), 32'(exp_link));
      check_counters({tag, ".c2"});
      check({tag, ".c2.req_ready"}, 32'(req_ready), 32'd0);

      @(posedge clk); #1;                     // cycle 3
      check({tag, ".c3.req_ready"}, 32'(req_ready), 32'd1);
      check({tag, ".c3.done"}, 32'(done), 32'd0);
      check({tag, ".c3.bad_op"}, 32'(bad_op), 32'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".pc_load"}, 32'(pc_load), 32'd0);
    check({tag, ".link_we"}, 32'(link_we), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".bad_op"}, 32'(bad_op), 32'd0);
    check({tag, ".pc_next"}, 32'(pc_next), 32'd0);
    check({tag, ".link_data"}, 32'(link_data), 32'd0);
    check({tag, ".taken_count"}, 32'(taken_count), 32'd0);
    check({tag, ".not_taken_count"}, 32'(not_taken_count), 32'd0);
  endtask

  // Random instruction from one of the supported classes or an illegal opcode.
  function automatic logic [15:0] rand_ir();
    logic [15:0] v;
    logic [3:0]  op;
    v = 16'($urandom);
    case ($urandom % 5)
      0: v[15:12] = 4'd0;                                    // BR
      1: v = {4'b1100, 3'b000, v[8:6], 6'b000000};           // JMP/RET
      2: v = {4'b0100, 1'b1, v[10:0]};                       // JSR
      3: v = {4'b0100, 3'b000, v[8:6], 6'b000000};           // JSRR
      default: begin
        do op = 4'($urandom); while (op == 4'd0 || op == 4'd4 || op == 4'd12);
        v[15:12] = op;
      end
    endcase
    return v;
  endfunction

  initial begin
    // Reset state.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_release.req_ready", 32'(req_ready), 32'd1);

    // Directed cases.
    run("brz",      16'h05FF, 16'h3001, 16'h0000, 0, 1, 0, 0, 1, 0);
    run("brn_snap", 16'h0805, 16'h3001, 16'h0000, 0, 0, 1, 1, 0, 0);
    run("jsr",      16'h4BFF, 16'h3001, 16'h1234, 0, 0, 1, 0, 0, 1);
    run("jsrr_r7",  16'h41C0, 16'h3001, 16'h4000, 1, 0, 0, 1, 0, 0);
    run("brnzp_wr", 16'h0E02, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 0, 1);
    run("add_bad",  16'h1000, 16'h2000, 16'h0000, 0, 1, 0, 0, 1, 0);
    run("br000",    16'h0003, 16'h2000, 16'h0000, 1, 1, 1, 1, 1, 1);
    run("ret",      16'hC1C0, 16'h3050, 16'hABCD, 0, 1, 0, 1, 0, 1);
    run("jmp_hold", 16'h0202, 16'h3333, 16'h0000, 1, 0, 0, 0, 0, 1);

    // Randomized instructions.
    for (int k = 0; k < 200; k++) begin
      bit [5:0] f;
      f = 6'($urandom);
      run("rand", rand_ir(), 16'($urandom), 16'($urandom),
          f[0], f[1], f[2], f[3], f[4], f[5]);
    end

    // Reset asserted while the unit sits in REDIRECT.
    wait_ready("rst_mid");
    ir = 16'hC080; pc = 16'h1111; base_data = 16'h5555; req_valid = 1'b1;
    @(posedge clk); #1;                       // accepted, now in EVAL
    req_valid = 1'b0;
    @(posedge clk); #1;                       // now in REDIRECT
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rst_mid");
    @(posedge clk); #1;
    check("rst_mid.no_late_pc_load", 32'(pc_load), 32'd0);
    check("rst_mid.no_late_done", 32'(done), 32'd0);
    reset = 1'b1;
    exp_pc_next = '0; exp_link = '0; exp_taken = 0; exp_ntaken = 0;
    @(posedge clk); #1;
    check("rst_mid.req_ready", 32'(req_ready), 32'd1);
    check("rst_mid.pc_load_after", 32'(pc_load), 32'd0);

    // The unit must resume cleanly with counters counting from zero.
    run("post_rst", 16'h4802, 16'h7FFF, 16'h0000, 0, 0, 0, 0, 0, 0);
    run("post_rst2", 16'hF025, 16'h0100, 16'h0000, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc3_branch_unit.md
# lc3_branch_unit

Downstream consumer of the n/z/p condition-code flags. Accepts one control-flow instruction at a time (BR, JMP/RET, JSR/JSRR) together with the incremented PC and BaseR value. It evaluates the branch condition against a flag snapshot, computes the target, and issues a one-cycle PC redirect and R7 link write to the datapath. It sits between the condition-code register and the PC/register-file write ports.

## Interface
- `WIDTH`, default 16: datapath width. Only 16 is supported.
- `STAT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  : clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-low reset.
- `req_valid`  in  1  : instruction request valid.
- `req_ready`  out  1  : unit idle and able to accept.
- `ir`  in  16  : instruction word.
- `pc`  in  16  : incremented PC (PC+1) of the instruction.
- `base_data`  in  16  : BaseR contents for JMP/JSRR.
- `n_flag`, `z_flag`, `p_flag`  in  1 each  : current condition codes.
- `pc_load`  out  1  : one-cycle strobe to load `pc_next` into PC.
- `pc_next`  out  16  : redirect target.
- `link_we`  out  1  : one-cycle R7 write strobe.
- `link_data`  out  16  : value written to R7.
- `done`  out  1  : one-cycle completion strobe.
- `bad_op`  out  1  : asserted with `done` when the opcode is unsupported.
- `taken_count`  out  STAT_W  : taken-redirect counter.
- `not_taken_count`  out  STAT_W  : not-taken counter.

## Operation
- FSM states: IDLE, EVAL, REDIRECT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid && req_ready`: capture `ir`, `pc`, `base_data` and the n/z/p snapshot, then go to EVAL.
  - Flag changes after capture never affect the decision.
- **EVAL** decodes `ir[15:12]`:
  - 0000 BR: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p); target = pc + sext(ir[8:0]). nzp=000 is never taken; nzp=111 is always taken.
  - 1100 JMP/RET: taken=1; target = captured base_data.
  - 0100 JSR (ir[11]=1): target = pc + sext(ir[10:0]).
  - 0100 JSRR (ir[11]=0): target = captured base_data.
  - JSR and JSRR: taken=1, link=1.
  - Any other opcode: not taken; bad_op latched.
  - Next state: taken → REDIRECT, else → DONE.
- **REDIRECT**
  - `pc_load`=1 and `pc_next`=target for exactly one cycle.
  - If link: `link_we`=1 and `link_data`=captured pc in the same cycle.
  - Next state: DONE.
- **DONE**
  - `done`=1 for one cycle; `bad_op`=1 in this cycle if latched.
  - Next state: IDLE.
- Arithmetic is modulo 2^16; target wrap-around is silent.
- JSRR with BaseR=R7 uses the captured pre-link base value.
- `pc_next` and `link_data` hold their last value outside strobes.
- `req_valid` outside IDLE is ignored. No queuing.

## Timing
- Reset (`reset`=0 at an edge):
  - state → IDLE.
  - `pc_load`, `link_we`, `done`, `bad_op` = 0.
  - `pc_next`, `link_data` = 0x0000.
  - Counters = 0.
  - `req_ready`=0 while `reset` is low.
- Reset mid-operation aborts the instruction. No strobe is issued afterwards.
- All outputs are registered (Moore). Take acceptance edge = cycle 0:
  - Taken: `pc_load`/`link_we` in cycle 2, `done` in cycle 3, `req_ready` again in cycle 4.
  - Not taken / bad_op: `done` in cycle 2, `req_ready` in cycle 3.
- `pc_load` and `done` are never asserted in the same cycle.

## Configuration
- Macro: `LC3_BRANCH_STATS_EN`.
- Defined:
  - `taken_count` increments on each REDIRECT entry.
  - `not_taken_count` increments on each EVAL→DONE transition (includes bad_op).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: counter logic is absent; both ports are tied to 0. The port list is unchanged.

## Test plan
- BRz, z=1, pc=0x3001, ir=0x05FF → cycle 2: `pc_load`=1, `pc_next`=0x3000; cycle 3: `done`=1.
- BRn, flags p=1 at capture and n=1 the next cycle, ir=0x0805 → no `pc_load`; `done` in cycle 2; `not_taken_count` +1 (macro on).
- JSR ir=0x4BFF, pc=0x3001 → cycle 2: `pc_next`=0x3400, `link_we`=1, `link_data`=0x3001.
- JSRR R7 ir=0x41C0, base_data=0x4000, pc=0x3001 → `pc_next`=0x4000, `link_data`=0x3001.
- BRnzp ir=0x0E02, pc=0xFFFF → `pc_next`=0x0001. ir=0x1000 (ADD) → `done`=1 and `bad_op`=1 in cycle 2, with no `pc_load`.
- `reset`=0 during REDIRECT → next cycle all strobes 0 and counters 0; `req_ready`=1 once `reset` returns high.
